// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the uart_tr transmitter.
//   uart_state_t : transmitter FSM states (IDLE, START, DATA, STOP)
//   bit_cyc()    : sys_clk cycles per serial bit (integer truncation)
//   cnt_width()  : counter width able to hold 0..n-1 (never below 1 bit)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int bit_cyc(input int sys_clk_freq, input int bps);
    return sys_clk_freq / bps;
  endfunction

  // A one-cycle bit period would give clog2 = 0; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- bit-period timer for the UART transmitter.
//   sys_clk     : clock, rising edge
//   sys_reset_n : synchronous active-low reset
//   enable      : counts while high, counter held at 0 while low
//   bit_tick    : high in the last cycle of every bit period
module uart_baud_gen #(
  parameter int BIT_CYC = 5208,
  parameter int CNT_W   = 13
) (
  input  logic sys_clk,
  input  logic sys_reset_n,
  input  logic enable,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYC - 1);

  logic [CNT_W-1:0] baud_cnt;

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n || !enable) begin
      baud_cnt <= '0;
    end else if (baud_cnt == LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign bit_tick = enable && (baud_cnt == LAST);

endmodule

// File: rtl/uart_tr.sv
// uart_tr -- UART transmitter: 1 start bit, width data bits LSB first,
// 1 stop bit, no parity.
//   sys_clk      : clock, rising edge
//   sys_reset_n  : synchronous active-low reset (aborts any frame)
//   uart_tx_en   : transmit request, honoured only in IDLE
//   uart_tx_data : payload, captured with an accepted request
//   uart_tx_out  : registered serial line, idle high
//   uart_tx_done : one-cycle pulse in the last cycle of the stop bit
module uart_tr
  import uart_pkg::*;
#(
  parameter int width        = 8,
  parameter int BPS          = 9_600,
  parameter int SYS_CLK_FREQ = 50_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  input  logic             uart_tx_en,
  input  logic [width-1:0] uart_tx_data,
  output logic             uart_tx_out,
  output logic             uart_tx_done
);

  localparam int BIT_CYC = bit_cyc(SYS_CLK_FREQ, BPS);
  localparam int BAUD_W  = cnt_width(BIT_CYC);
  localparam int BIT_W   = cnt_width(width);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(width - 1);

  uart_state_t      state;
  logic [width-1:0] shift_reg;
  logic [BIT_W-1:0] bit_cnt;
  logic             tx_out_reg;
  logic             bit_tick;

  // The timer runs in every state but IDLE, so the edge that accepts a
  // request starts a full bit period for the start bit.
  uart_baud_gen #(
    .BIT_CYC (BIT_CYC),
    .CNT_W   (BAUD_W)
  ) u_baud_gen (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .enable      (state != IDLE),
    .bit_tick    (bit_tick)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      tx_out_reg <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (uart_tx_en) begin
            state      <= START;
            shift_reg  <= uart_tx_data;
            tx_out_reg <= 1'b0;
          end
        end
        START: begin
          if (bit_tick) begin
            state      <= DATA;
            tx_out_reg <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_BIT) begin
              state      <= STOP;
              bit_cnt    <= '0;
              tx_out_reg <= 1'b1;
            end else begin
              // Drive the next bit straight from shift_reg[1] so the line
              // changes on the same edge the register shifts.
              bit_cnt    <= bit_cnt + 1'b1;
              shift_reg  <= shift_reg >> 1;
              tx_out_reg <= shift_reg[1];
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          tx_out_reg <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx_out  = tx_out_reg;
  // Decoded from registered state/counter only, so it is a clean pulse.
  assign uart_tx_done = (state == STOP) && bit_tick;

endmodule

// File: tb/tb_uart_tr.sv
// tb_uart_tr -- directed self-checking bench for uart_tr.
// Three instances share clock, reset and data: one at default parameters,
// one with BIT_CYC=4/width=8, one with BIT_CYC=4/width=5.
module tb_uart_tr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_def, en_s8, en_s5;
  logic [8:0] data;
  logic       line_def, line_s8, line_s5;
  logic       done_def, done_s8, done_s5;

  always #5 clk = ~clk;

  uart_tr dut_def (
    .sys_clk      (clk),
    .sys_reset_n  (rst_n),
    .uart_tx_en   (en_def),
    .uart_tx_data (data[7:0]),
    .uart_tx_out  (line_def),
    .uart_tx_done (done_def)
  );

  uart_tr #(.width(8), .BPS(10), .SYS_CLK_FREQ(40)) dut_s8 (
    .sys_clk      (clk),
    .sys_reset_n  (rst_n),
    .uart_tx_en   (en_s8),
    .uart_tx_data (data[7:0]),
    .uart_tx_out  (line_s8),
    .uart_tx_done (done_s8)
  );

  uart_tr #(.width(5), .BPS(10), .SYS_CLK_FREQ(40)) dut_s5 (
    .sys_clk      (clk),
    .sys_reset_n  (rst_n),
    .uart_tx_en   (en_s5),
    .uart_tx_data (data[4:0]),
    .uart_tx_out  (line_s5),
    .uart_tx_done (done_s5)
  );

  int   sel;
  logic line_sel, done_sel;

  always_comb begin
    line_sel = line_def;
    done_sel = done_def;
    case (sel)
      1: begin line_sel = line_s8; done_sel = done_s8; end
      2: begin line_sel = line_s5; done_sel = done_s5; end
      default: ;
    endcase
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  logic obs_first [0:10];
  logic obs_stable[0:10];
  int   done_cnt, done_at;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic v);
    case (sel)
      1:       en_s8 = v;
      2:       en_s5 = v;
      default: en_def = v;
    endcase
  endtask

  // Expected line level of frame bit k (0 = start, w+1 = stop).
  function automatic logic exp_bit(input int k, input int w, input logic [8:0] d);
    if (k == 0) return 1'b0;
    if (k > w) return 1'b1;
    return d[k-1];
  endfunction

  // Records one frame starting at the current cycle (first start-bit cycle):
  // level at the first cycle of each bit, whether it held for the whole bit,
  // and where uart_tx_done was seen. Optionally re-drives inputs mid-frame.
  task automatic capture_frame(input int b, input int w, input int poke_idx,
                               input logic [8:0] poke_data, input logic poke_en_after);
    int k;
    for (int j = 0; j <= 10; j++) begin
      obs_first[j]  = 1'bx;
      obs_stable[j] = 1'b1;
    end
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < (w + 2) * b; i++) begin
      k = i / b;
      if (i % b == 0) obs_first[k] = line_sel;
      else if (line_sel !== obs_first[k]) obs_stable[k] = 1'b0;
      if (done_sel === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
      if (i == poke_idx) begin
        data = poke_data;
        set_en(1'b1);
      end
      if (i == poke_idx + 1) set_en(poke_en_after);
      tick();
    end
  endtask

  task automatic test_reset();
    int bad_line, bad_done;
    bad_line = 0;
    bad_done = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({line_def, line_s8, line_s5} !== 3'b111) bad_line++;
      if ({done_def, done_s8, done_s5} !== 3'b000) bad_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({line_def, line_s8, line_s5} !== 3'b111) bad_line++;
      if ({done_def, done_s8, done_s5} !== 3'b000) bad_done++;
    end
    n_cmp++;
    if (bad_line !== 0) begin
      n_bad++;
      $display("FAIL reset_line: %0d cycles not idle-high, required 0", bad_line);
    end
    n_cmp++;
    if (bad_done !== 0) begin
      n_bad++;
      $display("FAIL reset_done: %0d cycles with done high, required 0", bad_done);
    end
    $display("test_reset: line/done checked during and after 4-cycle reset");
  endtask

  task automatic test_frame_55();
    sel = 0;
    data = 9'h055;
    en_def = 1'b1;
    tick();
    en_def = 1'b0;
    capture_frame(5208, 8, -1, 9'h0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (obs_first[k] !== exp_bit(k, 8, 9'h055) || obs_stable[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL f55_bit%0d: got %b stable=%b, required %b stable=1",
                 k, obs_first[k], obs_stable[k], exp_bit(k, 8, 9'h055));
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || done_at !== 52079) begin
      n_bad++;
      $display("FAIL f55_done: %0d pulses last at %0d, required 1 at 52079", done_cnt, done_at);
    end
    n_cmp++;
    if (line_def !== 1'b1 || done_def !== 1'b0) begin
      n_bad++;
      $display("FAIL f55_idle: line=%b done=%b, required 1/0", line_def, done_def);
    end
    $display("test_frame_55: 0x55 frame at defaults, done_at=%0d", done_at);
  endtask

  task automatic test_data_change();
    int bad;
    sel = 1;
    data = 9'h0A3;
    en_s8 = 1'b1;
    tick();
    en_s8 = 1'b0;
    capture_frame(4, 8, 20, 9'h0FF, 1'b0);
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (obs_first[k] !== exp_bit(k, 8, 9'h0A3) || obs_stable[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL chg_bit%0d: got %b stable=%b, required %b stable=1",
                 k, obs_first[k], obs_stable[k], exp_bit(k, 8, 9'h0A3));
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || done_at !== 39) begin
      n_bad++;
      $display("FAIL chg_done: %0d pulses last at %0d, required 1 at 39", done_cnt, done_at);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (line_s8 !== 1'b1 || done_s8 !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL chg_no_second: %0d non-idle cycles after frame, required 0", bad);
    end
    $display("test_data_change: 0xA3 frame kept, mid-frame request ignored");
  endtask

  task automatic test_back_to_back();
    sel = 1;
    data = 9'h000;
    en_s8 = 1'b1;
    tick();
    capture_frame(4, 8, 5, 9'h0FF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (obs_first[k] !== exp_bit(k, 8, 9'h000) || obs_stable[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b1_bit%0d: got %b stable=%b, required %b stable=1",
                 k, obs_first[k], obs_stable[k], exp_bit(k, 8, 9'h000));
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || done_at !== 39) begin
      n_bad++;
      $display("FAIL b2b1_done: %0d pulses last at %0d, required 1 at 39", done_cnt, done_at);
    end
    n_cmp++;
    if (line_s8 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_gap: line=%b in idle cycle, required 1", line_s8);
    end
    tick();
    en_s8 = 1'b0;
    capture_frame(4, 8, -1, 9'h0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (obs_first[k] !== exp_bit(k, 8, 9'h0FF) || obs_stable[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b2_bit%0d: got %b stable=%b, required %b stable=1",
                 k, obs_first[k], obs_stable[k], exp_bit(k, 8, 9'h0FF));
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || done_at !== 39) begin
      n_bad++;
      $display("FAIL b2b2_done: %0d pulses last at %0d, required 1 at 39", done_cnt, done_at);
    end
    tick();
    $display("test_back_to_back: 0x00 then 0xFF with en held high");
  endtask

  task automatic test_reset_mid_frame();
    int dones, bad;
    sel = 1;
    dones = 0;
    bad = 0;
    data = 9'h000;
    en_s8 = 1'b1;
    tick();
    en_s8 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (done_s8 === 1'b1) dones++;
      tick();
    end
    n_cmp++;
    if (line_s8 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_pre: line=%b in data bit 3, required 0", line_s8);
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (line_s8 !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_line: line=%b after reset edge, required 1", line_s8);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (done_s8 === 1'b1) dones++;
      if (line_s8 !== 1'b1) bad++;
      tick();
    end
    n_cmp++;
    if (dones !== 0 || bad !== 0) begin
      n_bad++;
      $display("FAIL rst_abort: %0d done pulses, %0d low cycles, required 0/0", dones, bad);
    end
    data = 9'h00F;
    en_s8 = 1'b1;
    tick();
    en_s8 = 1'b0;
    capture_frame(4, 8, -1, 9'h0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (obs_first[k] !== exp_bit(k, 8, 9'h00F) || obs_stable[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL rst_next_bit%0d: got %b stable=%b, required %b stable=1",
                 k, obs_first[k], obs_stable[k], exp_bit(k, 8, 9'h00F));
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || done_at !== 39) begin
      n_bad++;
      $display("FAIL rst_next_done: %0d pulses last at %0d, required 1 at 39", done_cnt, done_at);
    end
    $display("test_reset_mid_frame: abort in bit 3, then 0x0F frame");
  endtask

  task automatic test_small_params();
    sel = 2;
    data = 9'h01B;
    en_s5 = 1'b1;
    tick();
    en_s5 = 1'b0;
    capture_frame(4, 5, -1, 9'h0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (obs_first[k] !== exp_bit(k, 5, 9'h01B) || obs_stable[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL w5_bit%0d: got %b stable=%b, required %b stable=1",
                 k, obs_first[k], obs_stable[k], exp_bit(k, 5, 9'h01B));
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || done_at !== 27) begin
      n_bad++;
      $display("FAIL w5_done: %0d pulses last at %0d, required 1 at 27", done_cnt, done_at);
    end
    n_cmp++;
    if (line_s5 !== 1'b1 || done_s5 !== 1'b0) begin
      n_bad++;
      $display("FAIL w5_idle: line=%b done=%b after 28 cycles, required 1/0", line_s5, done_s5);
    end
    $display("test_small_params: width=5 BIT_CYC=4 frame of 0x1B");
  endtask

  initial begin
    sel = 0;
    rst_n = 1'b1;
    en_def = 1'b0;
    en_s8 = 1'b0;
    en_s5 = 1'b0;
    data = '0;
    #1;
    test_reset();
    test_small_params();
    test_data_change();
    test_back_to_back();
    test_reset_mid_frame();
    test_frame_55();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
